// File: rtl/fetch_redirect_ctrl.sv
// Front-end recovery sequencer: arbitrates trap and BRAT mispredict redirects, then drives a
// one-cycle flush/PC redirect/RAS restore followed by a programmable refill bubble.
module fetch_redirect_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  misprediction_i_0,
    input  logic                  misprediction_i_1,
    input  logic                  misprediction_i_2,
    input  logic [DATA_WIDTH-1:0] correct_pc_i_0,
    input  logic [DATA_WIDTH-1:0] correct_pc_i_1,
    input  logic [DATA_WIDTH-1:0] correct_pc_i_2,
    input  logic [2:0]            ras_tos_i_0,
    input  logic [2:0]            ras_tos_i_1,
    input  logic [2:0]            ras_tos_i_2,
    input  logic                  trap_valid_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic                  flush_o,
    output logic                  ras_restore_en_o,
    output logic [2:0]            ras_restore_tos_o,
    output logic                  buble_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  redirect_count_o
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StFlush, StHold} state_e;

    state_e                state_q, state_d;
    logic [HoldW-1:0]      hold_q, hold_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  restore_q;
    logic [2:0]            tos_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  count_q;

    logic                  req;
    logic [DATA_WIDTH-1:0] sel_pc;
    logic [2:0]            sel_tos;
    logic                  sel_restore;
    logic                  enter_flush;

    always_comb begin
        req         = trap_valid_i | misprediction_i_0 | misprediction_i_1 | misprediction_i_2;
        sel_pc      = correct_pc_i_2;
        sel_tos     = ras_tos_i_2;
        sel_restore = 1'b1;
        if (trap_valid_i) begin
            sel_pc      = trap_pc_i;
            sel_tos     = tos_q;  // traps leave the RAS checkpoint untouched
            sel_restore = 1'b0;
        end else if (misprediction_i_0) begin
            sel_pc  = correct_pc_i_0;
            sel_tos = ras_tos_i_0;
        end else if (misprediction_i_1) begin
            sel_pc  = correct_pc_i_1;
            sel_tos = ras_tos_i_1;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (req) state_d = StFlush;
            end
            StFlush: begin
                if (req) begin
                    state_d = StFlush;
                end else if (HOLD_CYCLES > 0) begin
                    state_d = StHold;
                    hold_d  = HoldW'(HOLD_CYCLES - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (req) begin
                    state_d = StFlush;
                end else if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        enter_flush = (state_d == StFlush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            restore_q <= 1'b0;
            tos_q     <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            valid_q   <= enter_flush;
            restore_q <= enter_flush & sel_restore;
            busy_q    <= (state_d != StIdle);
            if (enter_flush) begin
                pc_q  <= {sel_pc[DATA_WIDTH-1:2], 2'b00};
                tos_q <= sel_tos;
                if (count_q != '1) count_q <= count_q + 1'b1;
            end
        end
    end

    assign redirect_valid_o  = valid_q;
    assign flush_o           = valid_q;
    assign redirect_pc_o     = pc_q;
    assign ras_restore_en_o  = restore_q;
    assign ras_restore_tos_o = tos_q;
    assign buble_o           = busy_q;
    assign busy_o            = busy_q;
    assign redirect_count_o  = count_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: two instances (HOLD_CYCLES=2/CNT_WIDTH=16 and
// HOLD_CYCLES=0/CNT_WIDTH=2) share stimulus and are checked every cycle against a model.
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        mp0, mp1, mp2;
    logic [31:0] cpc0, cpc1, cpc2;
    logic [2:0]  tos0, tos1, tos2;
    logic        trap_valid;
    logic [31:0] trap_pc;

    logic        a_valid, a_flush, a_en, a_buble, a_busy;
    logic [31:0] a_pc;
    logic [2:0]  a_tos;
    logic [15:0] a_count;
    logic        b_valid, b_flush, b_en, b_buble, b_busy;
    logic [31:0] b_pc;
    logic [2:0]  b_tos;
    logic [1:0]  b_count;

    int checks   = 0;
    int failures = 0;

    fetch_redirect_ctrl #(.DATA_WIDTH(32), .HOLD_CYCLES(2), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset),
        .misprediction_i_0(mp0), .misprediction_i_1(mp1), .misprediction_i_2(mp2),
        .correct_pc_i_0(cpc0), .correct_pc_i_1(cpc1), .correct_pc_i_2(cpc2),
        .ras_tos_i_0(tos0), .ras_tos_i_1(tos1), .ras_tos_i_2(tos2),
        .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
        .redirect_valid_o(a_valid), .redirect_pc_o(a_pc), .flush_o(a_flush),
        .ras_restore_en_o(a_en), .ras_restore_tos_o(a_tos), .buble_o(a_buble),
        .busy_o(a_busy), .redirect_count_o(a_count)
    );

    fetch_redirect_ctrl #(.DATA_WIDTH(32), .HOLD_CYCLES(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .misprediction_i_0(mp0), .misprediction_i_1(mp1), .misprediction_i_2(mp2),
        .correct_pc_i_0(cpc0), .correct_pc_i_1(cpc1), .correct_pc_i_2(cpc2),
        .ras_tos_i_0(tos0), .ras_tos_i_1(tos1), .ras_tos_i_2(tos2),
        .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
        .redirect_valid_o(b_valid), .redirect_pc_o(b_pc), .flush_o(b_flush),
        .ras_restore_en_o(b_en), .ras_restore_tos_o(b_tos), .buble_o(b_buble),
        .busy_o(b_busy), .redirect_count_o(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request makes the next cycle a redirect; the bubble then persists for
    // `hold` further cycles unless a newer request restarts it.
    logic        m_req, m_en;
    logic [31:0] m_pc;
    logic [2:0]  m_tos;
    logic        e_valid, e_en, e_busy_a, e_busy_b;
    logic [31:0] e_pc;
    logic [2:0]  e_tos;
    int          left_a, left_b, cnt_a, cnt_b;

    always_comb begin
        m_req = trap_valid || mp0 || mp1 || mp2;
        m_pc  = cpc2;
        m_tos = tos2;
        m_en  = 1'b1;
        if (trap_valid) begin
            m_pc  = trap_pc;
            m_tos = e_tos;
            m_en  = 1'b0;
        end else if (mp0) begin
            m_pc  = cpc0;
            m_tos = tos0;
        end else if (mp1) begin
            m_pc  = cpc1;
            m_tos = tos1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid  <= 1'b0;
            e_en     <= 1'b0;
            e_pc     <= '0;
            e_tos    <= '0;
            e_busy_a <= 1'b0;
            e_busy_b <= 1'b0;
            left_a   <= 0;
            left_b   <= 0;
            cnt_a    <= 0;
            cnt_b    <= 0;
        end else begin
            e_valid  <= m_req;
            e_en     <= m_req && m_en;
            if (m_req) begin
                e_pc  <= m_pc & ~32'h3;
                e_tos <= m_tos;
                cnt_a <= (cnt_a < 65535) ? cnt_a + 1 : cnt_a;
                cnt_b <= (cnt_b < 3) ? cnt_b + 1 : cnt_b;
            end
            e_busy_a <= m_req || left_a > 0;
            e_busy_b <= m_req || left_b > 0;
            left_a   <= m_req ? 2 : ((left_a > 0) ? left_a - 1 : 0);
            left_b   <= 0;
        end
    end

    always @(negedge clk) begin
        chk("a_valid", 64'(a_valid), 64'(e_valid));
        chk("a_flush", 64'(a_flush), 64'(e_valid));
        chk("a_pc", 64'(a_pc), 64'(e_pc));
        chk("a_en", 64'(a_en), 64'(e_en));
        chk("a_tos", 64'(a_tos), 64'(e_tos));
        chk("a_busy", 64'(a_busy), 64'(e_busy_a));
        chk("a_buble", 64'(a_buble), 64'(e_busy_a));
        chk("a_count", 64'(a_count), 64'(cnt_a));
        chk("b_valid", 64'(b_valid), 64'(e_valid));
        chk("b_flush", 64'(b_flush), 64'(e_valid));
        chk("b_pc", 64'(b_pc), 64'(e_pc));
        chk("b_en", 64'(b_en), 64'(e_en));
        chk("b_tos", 64'(b_tos), 64'(e_tos));
        chk("b_busy", 64'(b_busy), 64'(e_busy_b));
        chk("b_buble", 64'(b_buble), 64'(e_busy_b));
        chk("b_count", 64'(b_count), 64'(cnt_b));
    end

    task automatic clr();
        mp0 = 0; mp1 = 0; mp2 = 0; trap_valid = 0;
        cpc0 = 0; cpc1 = 0; cpc2 = 0; trap_pc = 0;
        tos0 = 0; tos1 = 0; tos2 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        step();
        step();
        reset = 1'b0;
        step();
        chk("lit_reset_busy", 64'(a_busy), 64'd0);
        chk("lit_reset_count", 64'(a_count), 64'd0);

        // Reset while in HOLD
        mp0 = 1; cpc0 = 32'h300; tos0 = 3'd2;
        step();
        clr();
        step();
        chk("lit_hold_busy", 64'(a_busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("lit_rst_busy", 64'(a_busy), 64'd0);
        chk("lit_rst_pc", 64'(a_pc), 64'd0);
        chk("lit_rst_count", 64'(a_count), 64'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("lit_idle_valid", 64'(a_valid), 64'd0);
        chk("lit_idle_buble", 64'(a_buble), 64'd0);

        // Single slot1 mispredict
        mp1 = 1; cpc1 = 32'h0000_1006; tos1 = 3'd5;
        step();
        clr();
        chk("lit_s1_valid", 64'(a_valid), 64'd1);
        chk("lit_s1_flush", 64'(a_flush), 64'd1);
        chk("lit_s1_en", 64'(a_en), 64'd1);
        chk("lit_s1_pc", 64'(a_pc), 64'h1004);
        chk("lit_s1_tos", 64'(a_tos), 64'd5);
        chk("lit_s1_count", 64'(a_count), 64'd1);
        chk("lit_b_s1_valid", 64'(b_valid), 64'd1);
        step();
        chk("lit_b_idle_after", 64'(b_busy), 64'd0);
        chk("lit_s1_valid_drop", 64'(a_valid), 64'd0);
        step();
        chk("lit_s1_buble_t3", 64'(a_buble), 64'd1);
        step();
        chk("lit_s1_buble_t4", 64'(a_buble), 64'd0);

        // Trap beats slot0
        trap_valid = 1; trap_pc = 32'h0000_0100;
        mp0 = 1; cpc0 = 32'h0000_0200; tos0 = 3'd7;
        step();
        clr();
        chk("lit_trap_pc", 64'(a_pc), 64'h100);
        chk("lit_trap_en", 64'(a_en), 64'd0);
        chk("lit_trap_tos", 64'(a_tos), 64'd5);
        chk("lit_trap_count", 64'(a_count), 64'd2);
        repeat (4) step();

        // Slots 1 and 2 together
        mp1 = 1; cpc1 = 32'h2000; tos1 = 3'd3;
        mp2 = 1; cpc2 = 32'h3000; tos2 = 3'd6;
        step();
        clr();
        chk("lit_s12_pc", 64'(a_pc), 64'h2000);
        chk("lit_s12_tos", 64'(a_tos), 64'd3);
        step();
        chk("lit_s12_one_pulse", 64'(a_valid), 64'd0);
        repeat (3) step();

        // Back-to-back requests in FLUSH and HOLD
        mp2 = 1; cpc2 = 32'h4000; tos2 = 3'd1;
        step();
        clr();
        mp0 = 1; cpc0 = 32'h5008; tos0 = 3'd4;
        step();
        clr();
        chk("lit_b2b_pc1", 64'(a_pc), 64'h5008);
        chk("lit_b2b_valid1", 64'(a_valid), 64'd1);
        chk("lit_b2b_count1", 64'(a_count), 64'd5);
        step();
        chk("lit_b2b_hold_valid", 64'(a_valid), 64'd0);
        mp1 = 1; cpc1 = 32'h600c; tos1 = 3'd0;
        step();
        clr();
        chk("lit_b2b_pc2", 64'(a_pc), 64'h600c);
        chk("lit_b2b_count2", 64'(a_count), 64'd6);
        step();
        step();
        chk("lit_b2b_buble_hold", 64'(a_buble), 64'd1);
        step();
        chk("lit_b2b_buble_rel", 64'(a_buble), 64'd0);
        chk("lit_b_count_sat", 64'(b_count), 64'd3);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
